// File: rtl/cpu_sim_seq.sv
// CPU-side bus stimulus generator for PPU bring-up: init sequence (CTRL with
// verified readback, MASK, palette upload) then a per-NMI CTRL/STATUS/scroll frame.
module cpu_sim_seq #(
  parameter logic [7:0] START_X             = 8'd0,
  parameter logic [7:0] START_Y             = 8'd0,
  parameter int         AUTOSCROLL_X_FRAMES = 0,
  parameter int         AUTOSCROLL_Y_FRAMES = 0,
  parameter logic [7:0] CTRL_WORD           = 8'h90,
  parameter logic [7:0] MASK_WORD           = 8'h1E,
  parameter int         PAL_LEN             = 32,
  parameter logic [7:0] PAL_BASE            = 8'h0F,
  parameter int         MAX_RETRIES         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  input  logic [7:0]  data_i,
  output logic        rw,
  output logic [15:0] addr,
  output logic [7:0]  data_o,
  output logic        busy,
  output logic        fault,
  output logic        overrun,
  output logic [7:0]  xscroll,
  output logic [7:0]  yscroll
);

  typedef enum logic [3:0] {
    BOOT, INIT_CTRL, INIT_VER, MASK, PAL_HI, PAL_LO, PAL_DATA,
    IDLE, F_CTRL, F_VER, F_STAT, F_SX, F_SY, FAULT
  } state_t;

  localparam logic        AX_EN      = (AUTOSCROLL_X_FRAMES > 0);
  localparam logic        AY_EN      = (AUTOSCROLL_Y_FRAMES > 0);
  localparam logic [15:0] AX_LAST    = 16'(AUTOSCROLL_X_FRAMES - 1);
  localparam logic [15:0] AY_LAST    = 16'(AUTOSCROLL_Y_FRAMES - 1);
  localparam logic [5:0]  PAL_LAST   = 6'(PAL_LEN - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);
  localparam logic        PAL_ENABLE = (PAL_LEN > 0);

  state_t      r_state;
  logic        r_nmi, r_left, r_right, r_up, r_down;
  logic        r_pending, r_overrun;
  logic [3:0]  r_retry;
  logic [5:0]  r_pal_idx;
  logic [15:0] r_ax_cnt, r_ay_cnt;
  logic [7:0]  r_xscroll, r_yscroll;

  logic        w_nmi_re, w_left_re, w_right_re, w_up_re, w_down_re;
  logic        w_ax, w_ay, w_ctrl_ok, w_active;
  logic [3:0]  w_retry_inc;
  logic [7:0]  w_x_next, w_y_next;
  logic [9:0]  w_y_sum;

  assign w_nmi_re   = nmi & ~r_nmi;
  assign w_left_re  = left & ~r_left;
  assign w_right_re = right & ~r_right;
  assign w_up_re    = up & ~r_up;
  assign w_down_re  = down & ~r_down;

  assign w_ax = AX_EN && w_nmi_re && (r_ax_cnt == AX_LAST);
  assign w_ay = AY_EN && w_nmi_re && (r_ay_cnt == AY_LAST);

  assign w_ctrl_ok   = (data_i == CTRL_WORD);
  assign w_retry_inc = r_retry + 4'd1;
  assign w_active    = !(r_state inside {IDLE, FAULT});

  // Y is biased by +240 so a -1 step never goes negative before the mod-240 fold.
  assign w_x_next = r_xscroll + {7'd0, w_right_re} + {7'd0, w_ax} - {7'd0, w_left_re};
  assign w_y_sum  = {2'd0, r_yscroll} + 10'd240 + {9'd0, w_down_re} + {9'd0, w_ay}
                  - {9'd0, w_up_re};

  always_comb begin
    if (w_y_sum >= 10'd480)      w_y_next = 8'(w_y_sum - 10'd480);
    else if (w_y_sum >= 10'd240) w_y_next = 8'(w_y_sum - 10'd240);
    else                         w_y_next = 8'(w_y_sum);
  end

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= BOOT;
      r_nmi     <= 1'b0;
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_retry   <= 4'd0;
      r_pal_idx <= 6'd0;
      r_ax_cnt  <= 16'd0;
      r_ay_cnt  <= 16'd0;
      r_xscroll <= START_X;
      r_yscroll <= START_Y;
    end else begin
      r_nmi     <= nmi;
      r_left    <= left;
      r_right   <= right;
      r_up      <= up;
      r_down    <= down;
      r_xscroll <= w_x_next;
      r_yscroll <= w_y_next;

      if (AX_EN && w_nmi_re) r_ax_cnt <= w_ax ? 16'd0 : r_ax_cnt + 16'd1;
      if (AY_EN && w_nmi_re) r_ay_cnt <= w_ay ? 16'd0 : r_ay_cnt + 16'd1;

      if (w_nmi_re && w_active) begin
        if (r_pending) r_overrun <= 1'b1;
        r_pending <= 1'b1;
      end

      case (r_state)
        BOOT:      r_state <= INIT_CTRL;
        INIT_CTRL: r_state <= INIT_VER;
        INIT_VER, F_VER: begin
          if (w_ctrl_ok) begin
            r_retry <= 4'd0;
            r_state <= (r_state == INIT_VER) ? MASK : F_STAT;
          end else begin
            r_retry <= w_retry_inc;
            if (w_retry_inc == RETRY_MAX) r_state <= FAULT;
            else r_state <= (r_state == INIT_VER) ? INIT_CTRL : F_CTRL;
          end
        end
        MASK:      r_state <= PAL_ENABLE ? PAL_HI : IDLE;
        PAL_HI:    r_state <= PAL_LO;
        PAL_LO: begin
          r_pal_idx <= 6'd0;
          r_state   <= PAL_DATA;
        end
        PAL_DATA: begin
          if (r_pal_idx == PAL_LAST) r_state <= IDLE;
          else r_pal_idx <= r_pal_idx + 6'd1;
        end
        IDLE: begin
          if (r_pending || w_nmi_re) begin
            r_pending <= 1'b0;
            r_state   <= F_CTRL;
          end
        end
        F_CTRL:  r_state <= F_VER;
        F_STAT:  r_state <= F_SX;
        F_SX:    r_state <= F_SY;
        F_SY:    r_state <= IDLE;
        FAULT:   r_state <= FAULT;
        default: r_state <= BOOT;
      endcase
    end
  end

  // NOTE: bus outputs get defaults first so no path through the case infers a latch.
  always_comb begin
    rw     = 1'b1;
    addr   = 16'h0000;
    data_o = 8'h00;
    case (r_state)
      INIT_CTRL, F_CTRL: begin rw = 1'b0; addr = 16'h2000; data_o = CTRL_WORD; end
      INIT_VER, F_VER:   addr = 16'h2000;
      MASK:              begin rw = 1'b0; addr = 16'h2001; data_o = MASK_WORD; end
      PAL_HI:            begin rw = 1'b0; addr = 16'h2006; data_o = 8'h3F; end
      PAL_LO:            begin rw = 1'b0; addr = 16'h2006; data_o = 8'h00; end
      PAL_DATA:          begin rw = 1'b0; addr = 16'h2007; data_o = PAL_BASE + {2'd0, r_pal_idx}; end
      F_STAT:            addr = 16'h2002;
      F_SX:              begin rw = 1'b0; addr = 16'h2005; data_o = r_xscroll; end
      F_SY:              begin rw = 1'b0; addr = 16'h2005; data_o = r_yscroll; end
      default: ;
    endcase
  end

  assign busy    = !(r_state inside {BOOT, IDLE, FAULT});
  assign fault   = (r_state == FAULT);
  assign overrun = r_overrun;
  assign xscroll = r_xscroll;
  assign yscroll = r_yscroll;

endmodule

// File: tb/tb_cpu_sim_seq.sv
// Bench for cpu_sim_seq: a transaction-queue model checked every cycle, plus
// hand-computed bus traces and scroll values for the directed scenarios.
module tb_cpu_sim_seq;

  localparam logic [7:0] CTRL = 8'h90;
  localparam logic [7:0] MSK  = 8'h1E;
  localparam logic [7:0] PALB = 8'h0F;
  localparam int SX = 5, SY = 239, AXF = 2, AYF = 0, PLEN = 4, MAXR = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic nmi = 1'b0, left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
  logic good = 1'b1;
  logic [7:0]  data_i;
  logic        rw, busy, fault, overrun;
  logic [15:0] addr;
  logic [7:0]  data_o, xscroll, yscroll;

  assign data_i = good ? CTRL : 8'h00;

  cpu_sim_seq #(
    .START_X(8'(SX)), .START_Y(8'(SY)),
    .AUTOSCROLL_X_FRAMES(AXF), .AUTOSCROLL_Y_FRAMES(AYF),
    .CTRL_WORD(CTRL), .MASK_WORD(MSK), .PAL_LEN(PLEN), .PAL_BASE(PALB),
    .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .nmi(nmi), .left(left), .right(right), .up(up),
    .down(down), .data_i(data_i), .rw(rw), .addr(addr), .data_o(data_o),
    .busy(busy), .fault(fault), .overrun(overrun), .xscroll(xscroll),
    .yscroll(yscroll)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  bit en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- model: expected bus cycles as a queue; empty queue means idle ----
  typedef struct {
    bit rw; logic [15:0] addr; logic [7:0] data; bit busy; int kind;
  } item_t;  // kind: 0 fixed, 1 X scroll, 2 Y scroll, 3 CTRL verify read

  item_t m_q[$];
  int m_x, m_y, m_retry, m_cx, m_cy;
  bit m_pend, m_ovr, m_fault, p_nmi, p_l, p_r, p_u, p_d;

  function automatic item_t mk(bit r, logic [15:0] a, logic [7:0] d, bit b, int k);
    item_t it;
    it.rw = r; it.addr = a; it.data = d; it.busy = b; it.kind = k;
    return it;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_q.push_back(mk(1, 16'h0000, 8'h00, 0, 0));
    m_q.push_back(mk(0, 16'h2000, CTRL, 1, 0));
    m_q.push_back(mk(1, 16'h2000, 8'h00, 1, 3));
    m_q.push_back(mk(0, 16'h2001, MSK, 1, 0));
    if (PLEN > 0) begin
      m_q.push_back(mk(0, 16'h2006, 8'h3F, 1, 0));
      m_q.push_back(mk(0, 16'h2006, 8'h00, 1, 0));
      for (int i = 0; i < PLEN; i++) m_q.push_back(mk(0, 16'h2007, 8'(PALB + i), 1, 0));
    end
    m_x = SX; m_y = SY; m_retry = 0; m_cx = 0; m_cy = 0;
    m_pend = 0; m_ovr = 0; m_fault = 0;
    p_nmi = 0; p_l = 0; p_r = 0; p_u = 0; p_d = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      item_t cur;
      bit nre, lre, rre, ure, dre, ax, ay;
      nre = nmi && !p_nmi; lre = left && !p_l; rre = right && !p_r;
      ure = up && !p_u;    dre = down && !p_d;
      if (m_q.size() != 0) begin
        cur = m_q.pop_front();
        if (cur.kind == 3) begin
          if (data_i != CTRL) begin
            m_retry++;
            if (m_retry == MAXR) begin m_q.delete(); m_fault = 1; end
            else begin
              m_q.push_front(mk(1, 16'h2000, 8'h00, 1, 3));
              m_q.push_front(mk(0, 16'h2000, CTRL, 1, 0));
            end
          end else m_retry = 0;
        end
        if (nre) begin
          if (m_pend) m_ovr = 1;
          m_pend = 1;
        end
      end else if (!m_fault && (m_pend || nre)) begin
        m_pend = 0;
        m_q.push_back(mk(0, 16'h2000, CTRL, 1, 0));
        m_q.push_back(mk(1, 16'h2000, 8'h00, 1, 3));
        m_q.push_back(mk(1, 16'h2002, 8'h00, 1, 0));
        m_q.push_back(mk(0, 16'h2005, 8'h00, 1, 1));
        m_q.push_back(mk(0, 16'h2005, 8'h00, 1, 2));
      end
      ax = 0; ay = 0;
      if (AXF > 0 && nre) begin
        if (m_cx == AXF - 1) begin ax = 1; m_cx = 0; end else m_cx++;
      end
      if (AYF > 0 && nre) begin
        if (m_cy == AYF - 1) begin ay = 1; m_cy = 0; end else m_cy++;
      end
      m_x = (m_x + int'(rre) - int'(lre) + int'(ax) + 256) % 256;
      m_y = (m_y + int'(dre) - int'(ure) + int'(ay) + 240) % 240;
      p_nmi = nmi; p_l = left; p_r = right; p_u = up; p_d = down;
    end
  end

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    if (en) begin
      item_t e;
      if (m_q.size() == 0) e = mk(1, 16'h0000, 8'h00, 0, 0);
      else e = m_q[0];
      if (e.kind == 1) e.data = 8'(m_x);
      if (e.kind == 2) e.data = 8'(m_y);
      check("bus{rw,addr,data,busy}", {7'd0, rw, addr, data_o, busy},
            {7'd0, e.rw, e.addr, e.data, e.busy});
      check("flags{fault,overrun}", {30'd0, fault, overrun}, {30'd0, m_fault, m_ovr});
      check("xscroll", {24'd0, xscroll}, 32'(m_x));
      check("yscroll", {24'd0, yscroll}, 32'(m_y));
    end
  end

  // ---- trace of busy bus cycles for literal checks ----
  logic [24:0] log_q[$];
  always @(negedge clk) if (!rst && busy) log_q.push_back({rw, addr, data_o});

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    log_q.delete();
  endtask

  // {nmi,left,right,up,down} high for one cycle, then low for one
  task automatic pulse(input logic [4:0] m);
    {nmi, left, right, up, down} = m;
    step();
    {nmi, left, right, up, down} = 5'd0;
    step();
  endtask

  task automatic frame(input logic [7:0] ex, input logic [7:0] ey);
    log_q.delete();
    pulse(5'b10000);
    step(6);
    check("frame_len", log_q.size(), 5);
    check("frame_ctrl", log_q[0], 25'h0200090);
    check("frame_ver", log_q[1], 25'h1200000);
    check("frame_stat", log_q[2], 25'h1200200);
    check("frame_sx", log_q[3], {1'b0, 16'h2005, ex});
    check("frame_sy", log_q[4], {1'b0, 16'h2005, ey});
  endtask

  logic [24:0] exp_init [9] = '{25'h0200090, 25'h1200000, 25'h020011E, 25'h020063F,
                                25'h0200600, 25'h020070F, 25'h0200710, 25'h0200711,
                                25'h0200712};

  initial begin
    int n_stat;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    log_q.delete();
    en = 1'b1;

    // init sequence with good readback
    step(12);
    check("init_len", log_q.size(), 9);
    for (int i = 0; i < 9; i++) check("init_trace", log_q[i], exp_init[i]);
    check("init_busy", {31'd0, busy}, 0);
    check("init_x", xscroll, 8'd5);
    check("init_y", yscroll, 8'd239);

    // buttons and frames; X autoscroll steps on every 2nd NMI
    pulse(5'b00100);                  check("right_x", xscroll, 8'd6);
    frame(8'h06, 8'hEF);
    pulse(5'b01000); pulse(5'b01000); check("left2_x", xscroll, 8'd4);
    frame(8'h05, 8'hEF);
    pulse(5'b00001);                  check("down_wrap_y", yscroll, 8'd0);
    pulse(5'b00010);                  check("up_wrap_y", yscroll, 8'd239);
    pulse(5'b01100);                  check("lr_cancel_x", xscroll, 8'd5);
    frame(8'h05, 8'hEF);
    frame(8'h06, 8'hEF);
    frame(8'h06, 8'hEF);
    frame(8'h07, 8'hEF);

    // two NMI edges during init: one frame afterwards, sticky overrun
    do_reset();
    step(2);
    pulse(5'b10000);
    pulse(5'b10000);
    step(20);
    check("ovr_flag", {31'd0, overrun}, 1);
    check("ovr_len", log_q.size(), 14);
    n_stat = 0;
    foreach (log_q[i]) if (log_q[i][23:8] == 16'h2002) n_stat++;
    check("ovr_frames", n_stat, 1);
    check("ovr_sx", log_q[12], 25'h0200506);
    step(10);
    check("ovr_sticky", {31'd0, overrun}, 1);

    // readback never matches: three CTRL/verify pairs then fault
    good = 1'b0;
    do_reset();
    step(12);
    check("fault_len", log_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check("fault_trace", log_q[i], (i % 2 == 0) ? 25'h0200090 : 25'h1200000);
    check("fault_flag", {31'd0, fault}, 1);
    check("fault_bus", {15'd0, rw, addr}, 32'h0001_0000);
    pulse(5'b10000); pulse(5'b10000); pulse(5'b00100);
    step(4);
    check("fault_quiet", log_q.size(), 6);
    check("fault_x", xscroll, 8'd7);

    // asynchronous reset in the middle of the MASK write
    good = 1'b1;
    do_reset();
    step(3);
    check("pre_abort", {15'd0, rw, addr}, 32'h0000_2001);
    #1 rst = 1'b1;
    #1 check("abort_bus", {7'd0, rw, addr, data_o, busy}, {7'd0, 1'b1, 16'h0000, 8'h00, 1'b0});
    step(2);
    rst = 1'b0;
    log_q.delete();
    step(12);
    check("restart_len", log_q.size(), 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
